// File: rtl/uart_msg_scheduler.sv
// uart_msg_scheduler: latches OPEN/WRONG/LOCK event requests as pending flags
// and hands them one at a time, by priority, to a string sender.
//
// Sender handshake: o_trigger is a one-cycle start pulse issued together with
// a stable o_status code. The sender acknowledges by raising i_sender_busy
// (sampled from the trigger cycle onward) and signals completion by dropping
// it. A missing acknowledge within ACK_TIMEOUT cycles discards the message.
// Every message, completed or timed out, is followed by GAP_CYCLES idle
// cycles before the next trigger. o_status holds its value until the next
// trigger.
module uart_msg_scheduler #(
  parameter int GAP_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_evt,
  input  logic       i_enable,
  input  logic       i_sender_busy,
  output logic [2:0] o_status,
  output logic       o_trigger,
  output logic [2:0] o_pending,
  output logic       o_active,
  output logic [7:0] o_drop_cnt,
  output logic       o_timeout,
  output logic [1:0] o_dbg_state
);

  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [2:0]    evt_d1;
  logic [2:0]    rise;
  logic [2:0]    clr;
  logic [2:0]    drop_bits;
  logic [1:0]    drop_inc;
  logic [8:0]    drop_sum;
  logic [2:0]    status_n;
  logic          trig_n;
  logic          to_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [TW-1:0] to_cnt, to_cnt_n;

  // A rise sets its pending bit; a rise on a bit that stays pending counts as
  // a drop. A rise on the bit being issued this cycle re-arms it (no drop).
  always_comb begin
    rise      = i_evt & ~evt_d1;
    drop_bits = rise & o_pending & ~clr;
    drop_inc  = {1'b0, drop_bits[0]} + {1'b0, drop_bits[1]} + {1'b0, drop_bits[2]};
    drop_sum  = {1'b0, o_drop_cnt} + {7'd0, drop_inc};
  end

  // Next-state and registered-output decode for the message sequencer.
  always_comb begin
    state_n  = state;
    status_n = o_status;
    trig_n   = 1'b0;
    to_n     = 1'b0;
    clr      = 3'b000;
    gap_n    = gap_cnt;
    to_cnt_n = to_cnt;
    case (state)
      IDLE: begin
        if (i_enable && (o_pending != 3'b000)) begin
          // WRONG > LOCK > OPEN; the one-hot bit doubles as the status code.
          if (o_pending[1])      clr = 3'b010;
          else if (o_pending[2]) clr = 3'b100;
          else                   clr = 3'b001;
          status_n = clr;
          trig_n   = 1'b1;
          to_cnt_n = '0;
          state_n  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (i_sender_busy) begin
          state_n = WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          to_n    = 1'b1;
          gap_n   = GAP_LOAD;
          state_n = GAP;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!i_sender_busy) begin
          gap_n   = GAP_LOAD;
          state_n = GAP;
        end
      end
      GAP: begin
        // Counter loaded with GAP_CYCLES; zero still spends one cycle here.
        if (gap_cnt <= GW'(1)) begin
          gap_n   = '0;
          state_n = IDLE;
        end else begin
          gap_n = gap_cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters, event history and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      evt_d1     <= 3'b000;
      gap_cnt    <= '0;
      to_cnt     <= '0;
      o_status   <= 3'b000;
      o_trigger  <= 1'b0;
      o_timeout  <= 1'b0;
      o_pending  <= 3'b000;
      o_drop_cnt <= 8'd0;
    end else begin
      state      <= state_n;
      evt_d1     <= i_evt;
      gap_cnt    <= gap_n;
      to_cnt     <= to_cnt_n;
      o_status   <= status_n;
      o_trigger  <= trig_n;
      o_timeout  <= to_n;
      o_pending  <= (o_pending & ~clr) | rise;
      o_drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  assign o_active    = (state != IDLE);
  assign o_dbg_state = state;

endmodule
